mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the pipeline's instruction fetch (IF) and

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store requesters.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int unsigned W         = 32,
    parameter int unsigned TO_CYCLES = 64,
    parameter int unsigned TO_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [W-1:0] if_addr,
    output logic [W-1:0] if_data,
    output logic         if_ready,
    output logic         if_stall,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [W-1:0] d_addr,
    input  logic [W-1:0] d_wdata,
    output logic [W-1:0] d_rdata,
    output logic         d_ready,
    output logic         d_stall,
    output logic         mem_en,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         bus_err
);

    typedef enum logic [1:0] {
        StIdle,
        StIfBusy,
        StDBusy
    } state_e;

    state_e          state_q, state_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [W-1:0]    mem_addr_q, mem_addr_d;
    logic [W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [W-1:0]    if_data_q, if_data_d;
    logic [W-1:0]    d_rdata_q, d_rdata_d;
    logic            if_ready_q, if_ready_d;
    logic            d_ready_q, d_ready_d;
    logic            bus_err_q, bus_err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            grant_d;
    logic            grant_if;
    logic            timeout;
`ifdef MEM_ARB_RR_EN
    logic            last_d_q, last_d_d;
`endif

    // Grant selection; only evaluated when the FSM is idle.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (d_req && if_req) begin
            grant_d = ~last_d_q;
        end else begin
            grant_d = d_req;
        end
`else
        grant_d = d_req;
`endif
        grant_if = if_req & ~grant_d;
    end

    assign timeout = (cnt_q == TO_W'(TO_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
`ifdef MEM_ARB_RR_EN
        last_d_d    = last_d_q;
`endif

        unique case (state_q)
            StIdle: begin
                // The ready cycle blocks a new grant: the finished requester still holds req.
                if (!if_ready_q && !d_ready_q) begin
                    if (grant_d) begin
                        state_d     = StDBusy;
                        mem_en_d    = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        cnt_d       = '0;
`ifdef MEM_ARB_RR_EN
                        last_d_d    = 1'b1;
`endif
                    end else if (grant_if) begin
                        state_d    = StIfBusy;
                        mem_en_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        cnt_d      = '0;
`ifdef MEM_ARB_RR_EN
                        last_d_d   = 1'b0;
`endif
                    end
                end
            end
            StIfBusy, StDBusy: begin
                if (mem_ack || timeout) begin
                    state_d  = StIdle;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                    end
                    if (state_q == StIfBusy) begin
                        if_ready_d = 1'b1;
                        if_data_d  = mem_ack ? mem_rdata : '0;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_ack) begin
                            d_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_data   = if_data_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign bus_err   = bus_err_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign d_stall   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention, timeout and async reset.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit Rr = 1'b1;
`else
    localparam bit Rr = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ready;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int vectors;
    int miscompares;

    mem_port_arbiter #(
        .W        (32),
        .TO_CYCLES(64),
        .TO_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_data  (if_data),
        .if_ready (if_ready),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .d_stall  (d_stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset state
        tick();
        tick();
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_if_data", if_data, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // Fetch with ack two cycles after mem_en
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        chk1("if_stall_req", if_stall, 1'b1);
        tick();
        chk1("if_mem_en", mem_en, 1'b1);
        chk32("if_mem_addr", mem_addr, 32'h100);
        chk1("if_mem_we", mem_we, 1'b0);
        chk1("if_ready_early", if_ready, 1'b0);
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        chk1("if_ready_pulse", if_ready, 1'b1);
        chk32("if_data", if_data, 32'hDEADBEEF);
        chk1("if_mem_en_drop", mem_en, 1'b0);
        chk1("if_stall_done", if_stall, 1'b0);
        if_req = 1'b0;
        tick();
        chk1("if_ready_once", if_ready, 1'b0);

        // Contention: both requesters held
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h200;
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        chk1("tie1_mem_en", mem_en, 1'b1);
        chk32("tie1_addr", mem_addr, 32'h200);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        chk1("tie1_d_ready", d_ready, 1'b1);
        chk1("tie1_if_ready", if_ready, 1'b0);
        chk32("tie1_d_rdata", d_rdata, 32'hCAFEF00D);
        chk1("tie1_d_stall", d_stall, 1'b0);
        chk1("tie1_if_stall", if_stall, 1'b1);
        tick();
        chk1("tie_gap_idle", mem_en, 1'b0);
        chk1("tie_gap_ready", d_ready, 1'b0);
        tick();
        chk1("tie2_mem_en", mem_en, 1'b1);
        chk32("tie2_addr", mem_addr, Rr ? 32'h100 : 32'h200);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 1'b0;
        chk1("tie2_d_ready", d_ready, Rr ? 1'b0 : 1'b1);
        chk1("tie2_if_ready", if_ready, Rr ? 1'b1 : 1'b0);
        chk32("tie2_d_rdata", d_rdata, Rr ? 32'hCAFEF00D : 32'h0BADF00D);
        d_req  = 1'b0;
        if_req = 1'b0;
        tick();
        tick();

        // Store with ack at k=0
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h12345678;
        tick();
        chk1("st_mem_en", mem_en, 1'b1);
        chk1("st_mem_we", mem_we, 1'b1);
        chk32("st_mem_addr", mem_addr, 32'h40);
        chk32("st_mem_wdata", mem_wdata, 32'h12345678);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        mem_ack = 1'b0;
        chk1("st_d_ready", d_ready, 1'b1);
        chk32("st_d_rdata_kept", d_rdata, Rr ? 32'hCAFEF00D : 32'h0BADF00D);
        chk1("st_mem_we_drop", mem_we, 1'b0);
        chk1("st_mem_en_drop", mem_en, 1'b0);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        chk1("st_d_ready_once", d_ready, 1'b0);

        // Load that never gets an ack
        d_req  = 1'b1;
        d_addr = 32'h300;
        tick();
        chk1("to_mem_en", mem_en, 1'b1);
        for (int i = 0; i < 63; i++) begin
            tick();
        end
        chk1("to_still_busy", mem_en, 1'b1);
        chk1("to_no_err_yet", bus_err, 1'b0);
        chk1("to_no_ready_yet", d_ready, 1'b0);
        tick();
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_d_ready", d_ready, 1'b1);
        chk32("to_d_rdata", d_rdata, 32'h0);
        chk1("to_mem_en_drop", mem_en, 1'b0);
        d_req = 1'b0;
        tick();
        chk1("to_ready_once", d_ready, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55;
        tick();
        mem_ack = 1'b0;
        tick();
        chk1("late_ack_d_ready", d_ready, 1'b0);
        chk1("late_ack_if_ready", if_ready, 1'b0);
        chk32("late_ack_d_rdata", d_rdata, 32'h0);
        chk1("bus_err_sticky", bus_err, 1'b1);

        // Asynchronous reset in the middle of a data transaction
        d_req  = 1'b1;
        d_addr = 32'h400;
        tick();
        chk1("ar_busy", mem_en, 1'b1);
        #2;
        rst   = 1'b0;
        d_req = 1'b0;
        #1;
        chk1("ar_mem_en", mem_en, 1'b0);
        chk1("ar_bus_err", bus_err, 1'b0);
        chk1("ar_d_ready", d_ready, 1'b0);
        chk1("ar_if_ready", if_ready, 1'b0);
        #2;
        rst = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h77;
        tick();
        mem_ack = 1'b0;
        chk1("ar_ack_d_ready", d_ready, 1'b0);
        chk1("ar_ack_mem_en", mem_en, 1'b0);
        chk32("ar_ack_d_rdata", d_rdata, 32'h0);
        if_req  = 1'b1;
        if_addr = 32'h500;
        tick();
        chk1("ar_if_mem_en", mem_en, 1'b1);
        chk32("ar_if_addr", mem_addr, 32'h500);
        mem_ack   = 1'b1;
        mem_rdata = 32'h600D600D;
        tick();
        mem_ack = 1'b0;
        chk1("ar_if_ready", if_ready, 1'b1);
        chk32("ar_if_data", if_data, 32'h600D600D);
        if_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
